// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// Optional masked compare is enabled with the SEQ_DET_MASK_EN macro.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PAT_RST_DEF = 4'b1101;
  localparam int FILL_W_DEF = $clog2(PAT_W_DEF + 1);

  // Detector control state, kept alongside the fill count.
  typedef logic [0:0] state_t;
  localparam state_t S_FILL  = 1'b0;
  localparam state_t S_ARMED = 1'b1;

  // Width of a counter that must hold 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Bit-stream, pattern-control and status bundle for seq_detector_param.
// pat_mask_in exists only when SEQ_DET_MASK_EN is defined.
interface seq_det_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  import seq_det_pkg::*;

  // in_valid qualifies in_data for one cycle; there is no ready, the detector
  // accepts every qualified bit, so the source never stalls.
  logic             in_valid;
  logic             in_data;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] pat_mask_in;
`endif
  logic             overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;
  state_t           dbg_state;
  logic [PAT_W-1:0] dbg_hist;

  modport master (
    output in_valid, in_data, pat_load, pat_in,
`ifdef SEQ_DET_MASK_EN
    output pat_mask_in,
`endif
    output overlap, cnt_clr,
    input  match, match_cnt, armed, dbg_state, dbg_hist
  );

  modport slave (
    input  in_valid, in_data, pat_load, pat_in,
`ifdef SEQ_DET_MASK_EN
    input  pat_mask_in,
`endif
    input  overlap, cnt_clr,
    output match, match_cnt, armed, dbg_state, dbg_hist
  );

endinterface

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating fill count.
// clr wins over shift; armed mirrors (fill == PAT_W) as a register.
module seq_det_hist #(
  parameter int PAT_W = 4,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clr,
  input  logic             bit_in,
  output logic [PAT_W-1:0] hist,
  output logic [FW-1:0]    fill,
  output logic             armed
);

  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist  <= '0;
      fill  <= '0;
      armed <= 1'b0;
    end else if (shift) begin
      hist <= {hist[PAT_W-2:0], bit_in};
      if (fill != FULL) begin
        fill <= fill + 1'b1;
      end
      // The window becomes full on this shift or already was.
      armed <= (fill == LAST) || (fill == FULL);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and a
// saturating match counter. Define SEQ_DET_MASK_EN for a don't-care mask.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               CNT_W   = 8
) (
  input logic     clk,
  input logic     rst,
  seq_det_if.slave bus
);

  localparam int FW = fill_w(PAT_W);
  localparam logic [FW-1:0]    LAST    = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] diff;
  logic [FW-1:0]    fill;
  logic             hist_armed;
  logic             hit;
  logic             hist_clr;
  logic             hist_shift;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;
  state_t           state;

  assign cand = {hist[PAT_W-2:0], bus.in_data};

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] pat_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_mask <= '1;
    end else if (bus.pat_load) begin
      pat_mask <= bus.pat_mask_in;
    end
  end

  assign diff = (cand ^ pat_reg) & pat_mask;
`else
  assign diff = cand ^ pat_reg;
`endif

  // A load cycle discards its bit, so it can never complete a match.
  assign hit        = bus.in_valid && !bus.pat_load && (diff == '0) && (fill >= LAST);
  assign hist_clr   = bus.pat_load || (hit && !bus.overlap);
  assign hist_shift = bus.in_valid && !hist_clr;

  seq_det_hist #(
    .PAT_W (PAT_W),
    .FW    (FW)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .shift  (hist_shift),
    .clr    (hist_clr),
    .bit_in (bus.in_data),
    .hist   (hist),
    .fill   (fill),
    .armed  (hist_armed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg <= PAT_RST;
    end else if (bus.pat_load) begin
      pat_reg <= bus.pat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
    end
  end

  // Clear is applied before the increment, so clear plus hit leaves one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
    end else begin
      case (state)
        S_FILL: begin
          if (hist_shift && (fill == LAST)) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (hist_clr) begin
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.armed     = hist_armed;
  assign bus.dbg_state = state;
  assign bus.dbg_hist  = hist;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector, the next generation of the fixed 4-bit pattern detector.
- Detection pattern is runtime-loadable.
- Detection is gated by a valid strobe; the detector stays silent until a full window of bits has been received.
- Overlapping and non-overlapping detection modes are selectable.
- A saturating match counter is kept.
- Sits between a serial input deserialiser and status/interrupt logic.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
PAT_RST, 4'b1101 (PAT_W bits), pattern value after reset
CNT_W, 8, width of match counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  data bit qualifier
in_data  input  1  serial data bit, newest bit enters LSB
pat_load  input  1  load new pattern this cycle
pat_in  input  PAT_W  pattern value to load
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  clear match counter
match  output  1  registered one-cycle match pulse
match_cnt  output  CNT_W  number of matches, saturating
armed  output  1  history window full (fill count == PAT_W)

Behaviour:
- Reset: rst sampled at posedge clk; highest priority over all other inputs.
  - Clears hist to 0, fill to 0, match to 0, match_cnt to 0, armed to 0.
  - Loads pat_reg with PAT_RST.
- History: on in_valid, hist <= {hist[PAT_W-2:0], in_data}.
  - fill increments, saturating at PAT_W.
  - armed = (fill == PAT_W), registered.
- Candidate window: cand = {hist[PAT_W-2:0], in_data}.
  - hit = in_valid and (cand == pat_reg) and (fill >= PAT_W-1).
- Timing: match <= hit. Match is registered, so the pulse is high in the cycle after the edge that samples the completing bit (one-cycle latency). Match is 0 whenever in_valid was 0.
- Overlapping mode (overlap=1): history continues unchanged after a hit.
  - Example: 1101101 gives two matches for pattern 1101.
- Non-overlapping mode (overlap=0): on a hit, hist <= 0 and fill <= 0 instead of the shift.
  - The next match needs PAT_W fresh bits.
- Pattern load: on pat_load, pat_reg <= pat_in; hist and fill are cleared.
  - The bit presented in the same cycle is discarded; hit is forced to 0 that cycle.
- Priority: rst > pat_load > normal shift/hit.
- Counter: on hit, match_cnt increments, saturating at all-ones.
  - cnt_clr sets match_cnt to 0.
  - cnt_clr together with hit in the same cycle: result is 1. The clear applies first, then the increment.
- Overlap changes take effect on the next sampled bit; no history flush.
- State machine (explicit 2-state, in addition to fill count):
  - FILL → ARMED when fill reaches PAT_W.
  - ARMED → FILL on a non-overlap hit, pat_load, or rst.
- Idle cycles (in_valid=0) hold all state.

Optional Feature:
Macro SEQ_DET_MASK_EN.
- Defined: adds input port pat_mask_in[PAT_W] and register pat_mask.
  - pat_mask is loaded together with pat_in on pat_load.
  - pat_mask resets to all-ones.
  - Compare becomes ((cand ^ pat_reg) & pat_mask) == 0. A mask bit of 0 means don't-care.
- Undefined: no port and no register; exact compare.

Decomposition:
- Package seq_det_pkg:
  - state enum (S_FILL, S_ARMED)
  - localparam for the fill-count width, $clog2(PAT_W+1)
  - default pattern constant
- Sub-module seq_det_hist: shift history plus fill counter, with shift, clear, and armed output.
- Top module holds the compare logic, FSM, match register and counter.

Test Plan:
- Default pattern 1101, overlap=1, stream 1101101 with all bits valid → match pulses on cycles 5 and 8 (1-based, counted from the first valid bit); match_cnt=2.
- Same stream with overlap=0 → single pulse on cycle 5; match_cnt=1.
- Stream 1,1,0,gap(in_valid=0 for 3 cycles),1 → single match one cycle after the final bit; no pulse during the gap.
- Reset right after reset release: first three bits 101 → no match, armed=0 until the 4th valid bit. Also assert rst in the same cycle as a completing bit → match stays 0, match_cnt=0.
- pat_load with pat_in=0110, then stream 0110 → match; old pattern 1101 → no match. The bit sent during the pat_load cycle is ignored.
- CNT_W=2: five matches → match_cnt saturates at 3. cnt_clr together with a hit → match_cnt=1.
